// File: rtl/uart_pkg.sv
// Shared types and constants for the framed UART receiver.
// Holds the parity mode, the receive FSM states and the majority-vote sample positions.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    // Three samples straddling the bit centre feed the 2-of-3 vote.
    function automatic int vote_lo(input int oversample);
        return oversample / 2 - 1;
    endfunction

    function automatic int vote_mid(input int oversample);
        return oversample / 2;
    endfunction

    function automatic int vote_hi(input int oversample);
        return oversample / 2 + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO; head visible the cycle after a write into an empty FIFO.
// Backpressure: a write is refused only when full with no simultaneous pop (wr_ok low).
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ok,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             do_wr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign rd_valid = !empty;
    assign pop      = rd_en && !empty;
    assign wr_ok    = !full || pop;
    assign do_wr    = wr_en && wr_ok;
    // Zero the head when empty so outputs read 0 after reset without resetting storage.
    assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_framed.sv
// Oversampling UART receiver with parity/framing/break detection feeding an output FIFO.
// Latency: entry visible 2 clocks after the last stop sample; backpressure via m_ready, full FIFO drops frames (overrun).
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int      CLOCK_FREQ = 50000000,
    parameter int      BAUD_RATE  = 115200,
    parameter int      DATA_BITS  = 8,
    parameter parity_t PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      OVERSAMPLE = 16,
    parameter int      FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_parity_err,
    output logic                 m_frame_err,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    output logic                 break_det
);
    localparam int DIV   = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW    = $clog2(OVERSAMPLE);
    localparam int BW    = $clog2(DATA_BITS + 1);
    localparam int FW    = DATA_BITS + 2;
    localparam int V_LO  = vote_lo(OVERSAMPLE);
    localparam int V_MID = vote_mid(OVERSAMPLE);
    localparam int V_HI  = vote_hi(OVERSAMPLE);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_framed: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_framed: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
        $error("uart_rx_framed: OVERSAMPLE must be a power of two >= 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_framed: FIFO_DEPTH must be a power of two >= 2");
    end
    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_framed: CLOCK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end

    rx_state_t            state, state_d;
    logic                 rx_meta, rx_sync, rx_prev;
    logic                 fall, tick, vote_now, bit_val, data_par, last_stop, is_break;
    logic                 push, brk;
    logic [TW-1:0]        tick_cnt;
    logic [SW-1:0]        samp_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic [1:0]           votes;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, par_err, frm_err;
    logic                 wr_en, wr_ok, brk_r;
    logic [FW-1:0]        wr_word, rd_word;

    assign fall      = rx_prev && !rx_sync;
    assign tick      = (tick_cnt == TW'(DIV - 1));
    assign vote_now  = tick && (samp_cnt == SW'(V_HI));
    // The third vote is the live synchronised sample taken this tick.
    assign bit_val   = (votes[0] & votes[1]) | (votes[0] & rx_sync) | (votes[1] & rx_sync);
    assign data_par  = (PARITY == PAR_ODD) ? ~^shreg : ^shreg;
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
    assign is_break  = (shreg == '0) && !par_bit && !bit_val;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        push    = 1'b0;
        brk     = 1'b0;
        case (state)
            ST_IDLE:   if (fall) state_d = ST_START;
            ST_START:  if (vote_now) state_d = bit_val ? ST_IDLE : ST_DATA;
            ST_DATA: begin
                if (vote_now && bit_cnt == BW'(DATA_BITS - 1))
                    state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            end
            ST_PARITY: if (vote_now) state_d = ST_STOP;
            ST_STOP: begin
                if (vote_now) begin
                    if (!stop_cnt && is_break) begin
                        brk     = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end else if (last_stop) begin
                        push    = 1'b1;
                        state_d = rx_sync ? ST_IDLE : ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (tick && rx_sync && samp_cnt == SW'(OVERSAMPLE - 1)) state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt  <= '0;
            samp_cnt  <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            votes     <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            par_err   <= 1'b0;
            frm_err   <= 1'b0;
            wr_en     <= 1'b0;
            wr_word   <= '0;
            brk_r     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            tick_cnt <= ((state == ST_IDLE && fall) || tick) ? '0 : tick_cnt + 1'b1;

            // WAIT_IDLE reuses the sample counter to time one full bit of continuous high.
            if (state == ST_IDLE || (state_d == ST_WAIT_IDLE && state != ST_WAIT_IDLE) ||
                (state == ST_WAIT_IDLE && !rx_sync))
                samp_cnt <= '0;
            else if (tick)
                samp_cnt <= samp_cnt + 1'b1;

            if (tick && samp_cnt == SW'(V_LO))  votes[0] <= rx_sync;
            if (tick && samp_cnt == SW'(V_MID)) votes[1] <= rx_sync;

            if (state != ST_DATA) bit_cnt <= '0;
            else if (vote_now)    bit_cnt <= bit_cnt + 1'b1;

            if (state != ST_STOP) stop_cnt <= 1'b0;
            else if (vote_now)    stop_cnt <= 1'b1;

            if (state == ST_DATA && vote_now) shreg <= {bit_val, shreg[DATA_BITS-1:1]};

            if (state == ST_START) begin
                par_bit <= 1'b0;
                par_err <= 1'b0;
                frm_err <= 1'b0;
            end else if (state == ST_PARITY && vote_now) begin
                par_bit <= bit_val;
                par_err <= bit_val ^ data_par;
            end else if (state == ST_STOP && vote_now) begin
                frm_err <= frm_err | ~bit_val;
            end

            wr_en <= push;
            if (push) wr_word <= {shreg, par_err, frm_err | ~bit_val};
            brk_r   <= brk;
            overrun <= wr_en && !wr_ok;
        end
    end

    uart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_data  (wr_word),
        .wr_ok    (wr_ok),
        .rd_en    (m_ready),
        .rd_data  (rd_word),
        .rd_valid (m_valid)
    );

    assign m_data       = rd_word[FW-1:2];
    assign m_parity_err = rd_word[1];
    assign m_frame_err  = rd_word[0];
    assign break_det    = brk_r;

endmodule
